// File: rtl/xc_rf_pkg.sv
// Shared constants and helpers for the GPR-file writeback scheduler slice.
package xc_rf_pkg;

  localparam int unsigned XC_RF_NREQ = 3;
  localparam int unsigned XC_RF_AW   = 5;
  localparam int unsigned XC_RF_DW   = 32;
  localparam int unsigned XC_RF_NREG = 32;

  localparam int unsigned XC_WB_ALU = 0;
  localparam int unsigned XC_WB_LSU = 1;
  localparam int unsigned XC_WB_XCU = 2;

  // Modulo-3 add used for the round-robin rotation; inputs are always 0..2.
  function automatic logic [1:0] xc_rr_add(input logic [1:0] base, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, base} + {1'b0, k};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // A source/destination is hazarded if busy and not being retired this very cycle.
  function automatic logic xc_hz(input logic [XC_RF_NREG-1:0] busy,
                                 input logic                  wen,
                                 input logic [XC_RF_AW-1:0]   waddr,
                                 input logic [XC_RF_AW-1:0]   r);
    return (r != '0) && busy[r] && !(wen && (waddr == r));
  endfunction

endpackage

// File: rtl/xc_rf_scoreboard.sv
// Busy-bit scoreboard for in-flight long-latency destinations plus issue hazard detect.
module xc_rf_scoreboard
  import xc_rf_pkg::*;
(
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  iss_valid,
  input  logic                  iss_long,
  input  logic [XC_RF_AW-1:0]   iss_rs1,
  input  logic [XC_RF_AW-1:0]   iss_rs2,
  input  logic [XC_RF_AW-1:0]   iss_rd,
  input  logic                  rd_wen,
  input  logic [XC_RF_AW-1:0]   rd_addr,
  output logic                  iss_stall,
  output logic [XC_RF_NREG-1:0] sb_busy
);

  logic [XC_RF_NREG-1:0] r_busy;
  logic [XC_RF_NREG-1:0] w_busy_nxt;
  logic                  w_stall;

  always_comb begin
    w_stall = iss_valid && (xc_hz(r_busy, rd_wen, rd_addr, iss_rs1) ||
                            xc_hz(r_busy, rd_wen, rd_addr, iss_rs2) ||
                            xc_hz(r_busy, rd_wen, rd_addr, iss_rd));
  end

  // Clear applied before set so a same-cycle set of the retiring register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (rd_wen) w_busy_nxt[rd_addr] = 1'b0;
    if (iss_valid && !w_stall && iss_long && (iss_rd != '0)) w_busy_nxt[iss_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  assign iss_stall = w_stall;
  assign sb_busy   = r_busy;

endmodule

// File: rtl/xc_rf_wb_sched.sv
// Writeback arbiter for the single rd port with registered write stage and hazard scoreboard.
module xc_rf_wb_sched
  import xc_rf_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                           clock,
  input  logic                           resetn,
  input  logic [XC_RF_NREQ-1:0]          wb_valid,
  output logic [XC_RF_NREQ-1:0]          wb_ready,
  input  logic [XC_RF_NREQ*XC_RF_AW-1:0] wb_addr,
  input  logic [XC_RF_NREQ*XC_RF_DW-1:0] wb_wdata,
  input  logic                           iss_valid,
  input  logic                           iss_long,
  input  logic [XC_RF_AW-1:0]            iss_rs1,
  input  logic [XC_RF_AW-1:0]            iss_rs2,
  input  logic [XC_RF_AW-1:0]            iss_rd,
  output logic                           iss_stall,
  output logic                           rd_wen,
  output logic [XC_RF_AW-1:0]            rd_addr,
  output logic [XC_RF_DW-1:0]            rd_wdata,
  output logic [XC_RF_NREG-1:0]          sb_busy
);

  logic [1:0]          r_ptr;
  logic                r_wen;
  logic [XC_RF_AW-1:0] r_addr;
  logic [XC_RF_DW-1:0] r_wdata;

  logic                w_gnt;
  logic [1:0]          w_gnt_idx;
  logic [1:0]          w_cand;
  logic [XC_RF_AW-1:0] w_gnt_addr;
  logic [XC_RF_DW-1:0] w_gnt_data;

  // Walk candidates in priority order; fixed mode ignores the pointer.
  always_comb begin
    w_gnt     = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < XC_RF_NREQ; k++) begin
      w_cand = RR_EN ? xc_rr_add(r_ptr, 2'(k)) : 2'(k);
      if (!w_gnt && wb_valid[w_cand]) begin
        w_gnt     = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  always_comb begin
    wb_ready   = w_gnt ? (XC_RF_NREQ'(1) << w_gnt_idx) : '0;
    w_gnt_addr = wb_addr[w_gnt_idx*XC_RF_AW +: XC_RF_AW];
    w_gnt_data = wb_wdata[w_gnt_idx*XC_RF_DW +: XC_RF_DW];
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ptr   <= '0;
      r_wen   <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_wen <= w_gnt && (w_gnt_addr != '0);
      if (w_gnt) begin
        r_addr  <= w_gnt_addr;
        r_wdata <= w_gnt_data;
        if (RR_EN) r_ptr <= xc_rr_add(w_gnt_idx, 2'd1);
      end
    end
  end

  xc_rf_scoreboard u_sb (
    .clock     (clock),
    .resetn    (resetn),
    .iss_valid (iss_valid),
    .iss_long  (iss_long),
    .iss_rs1   (iss_rs1),
    .iss_rs2   (iss_rs2),
    .iss_rd    (iss_rd),
    .rd_wen    (r_wen),
    .rd_addr   (r_addr),
    .iss_stall (iss_stall),
    .sb_busy   (sb_busy)
  );

  assign rd_wen   = r_wen;
  assign rd_addr  = r_addr;
  assign rd_wdata = r_wdata;

endmodule

// File: tb/tb_xc_rf_wb_sched.sv
// Bench for xc_rf_wb_sched: RR and fixed-priority instances against a behavioural model.
module tb_xc_rf_wb_sched;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  wb_valid = '0;
  logic [14:0] wb_addr = '0;
  logic [95:0] wb_wdata = '0;
  logic        iss_valid = 1'b0;
  logic        iss_long = 1'b0;
  logic [4:0]  iss_rs1 = '0;
  logic [4:0]  iss_rs2 = '0;
  logic [4:0]  iss_rd = '0;

  logic [2:0]  o_ready [2];
  logic        o_stall [2];
  logic        o_wen   [2];
  logic [4:0]  o_addr  [2];
  logic [31:0] o_data  [2];
  logic [31:0] o_busy  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  xc_rf_wb_sched #(.RR_EN(1'b1)) dut_rr (
    .clock(clock), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(o_ready[0]),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .iss_valid(iss_valid), .iss_long(iss_long),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_stall(o_stall[0]),
    .rd_wen(o_wen[0]), .rd_addr(o_addr[0]), .rd_wdata(o_data[0]), .sb_busy(o_busy[0])
  );

  xc_rf_wb_sched #(.RR_EN(1'b0)) dut_fx (
    .clock(clock), .resetn(resetn), .wb_valid(wb_valid), .wb_ready(o_ready[1]),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .iss_valid(iss_valid), .iss_long(iss_long),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_stall(o_stall[1]),
    .rd_wen(o_wen[1]), .rd_addr(o_addr[1]), .rd_wdata(o_data[1]), .sb_busy(o_busy[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: index 0 = round-robin instance, 1 = fixed-priority instance.
  int          m_ptr  [2];
  logic        m_wen  [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  bit          m_busy [2][32];

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_wen[m] = 1'b0; m_addr[m] = '0; m_data[m] = '0;
      for (int r = 0; r < 32; r++) m_busy[m][r] = 1'b0;
    end
  endtask

  function automatic bit m_hz(input int m, input logic [4:0] r);
    return (r != 0) && m_busy[m][r] && !(m_wen[m] && (m_addr[m] == r));
  endfunction

  always @(negedge resetn) model_reset();

  always @(negedge clock) begin
    if (!resetn) model_reset();
    for (int m = 0; m < 2; m++) begin
      int g;
      logic [2:0]  er;
      logic        es;
      logic [31:0] eb;
      g = -1;
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m == 0) ? (m_ptr[m] + k) % 3 : k;
        if (g < 0 && wb_valid[i]) g = i;
      end
      er = 3'b000;
      if (g >= 0) er[g] = 1'b1;
      es = iss_valid && (m_hz(m, iss_rs1) || m_hz(m, iss_rs2) || m_hz(m, iss_rd));
      for (int r = 0; r < 32; r++) eb[r] = m_busy[m][r];
      chk($sformatf("m%0d wb_ready", m), 64'(o_ready[m]), 64'(er));
      chk($sformatf("m%0d iss_stall", m), 64'(o_stall[m]), 64'(es));
      chk($sformatf("m%0d rd_wen", m), 64'(o_wen[m]), 64'(m_wen[m]));
      chk($sformatf("m%0d rd_addr", m), 64'(o_addr[m]), 64'(m_addr[m]));
      chk($sformatf("m%0d rd_wdata", m), 64'(o_data[m]), 64'(m_data[m]));
      chk($sformatf("m%0d sb_busy", m), 64'(o_busy[m]), 64'(eb));
      if (resetn) begin
        if (m_wen[m]) m_busy[m][m_addr[m]] = 1'b0;
        if (iss_valid && !es && iss_long && iss_rd != 0) m_busy[m][iss_rd] = 1'b1;
        if (g >= 0) begin
          m_addr[m] = wb_addr[5*g +: 5];
          m_data[m] = wb_wdata[32*g +: 32];
          m_wen[m]  = (m_addr[m] != 0);
          if (m == 0) m_ptr[m] = (g + 1) % 3;
        end else begin
          m_wen[m] = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] dat [3];
  logic [2:0]  rdy;

  initial begin
    dat[0] = 32'hAAAA_0001; dat[1] = 32'hBBBB_0002; dat[2] = 32'hCCCC_0003;
    rdy = '0;

    tick(); tick();
    for (int m = 0; m < 2; m++) begin
      chk("reset rd_wen", 64'(o_wen[m]), 64'd0);
      chk("reset rd_addr", 64'(o_addr[m]), 64'd0);
      chk("reset rd_wdata", 64'(o_data[m]), 64'd0);
      chk("reset sb_busy", 64'(o_busy[m]), 64'd0);
      chk("reset wb_ready", 64'(o_ready[m]), 64'd0);
      chk("reset iss_stall", 64'(o_stall[m]), 64'd0);
    end
    resetn = 1'b1;
    tick();

    // Round robin with three continuous requesters.
    wb_valid = 3'b111;
    wb_addr  = {5'd7, 5'd6, 5'd5};
    wb_wdata = {dat[2], dat[1], dat[0]};
    #1 chk("rr grant c0", 64'(o_ready[0]), 64'b001);
    for (int c = 1; c < 5; c++) begin
      tick();
      #1;
      chk("rr grant", 64'(o_ready[0]), 64'(3'b001 << (c % 3)));
      chk("rr rd_addr", 64'(o_addr[0]), 64'(5 + (c - 1) % 3));
      chk("rr rd_wen", 64'(o_wen[0]), 64'd1);
      chk("rr rd_wdata", 64'(o_data[0]), 64'(dat[(c - 1) % 3]));
    end
    tick();

    // Fixed priority: requester 1 beats 2 for as long as it is valid.
    wb_valid = 3'b110;
    #1 chk("fx grant c0", 64'(o_ready[1]), 64'b010);
    tick();
    #1 chk("fx grant c1", 64'(o_ready[1]), 64'b010);
    chk("fx rd_addr", 64'(o_addr[1]), 64'd6);
    wb_valid = '0;
    tick(); tick();

    // Long issue to x9, dependent issue stalls until the x9 writeback.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9; iss_rs1 = '0; iss_rs2 = '0;
    #1 chk("long issue stall", 64'(o_stall[0]), 64'd0);
    tick();
    iss_long = 1'b0; iss_rs1 = 5'd9; iss_rd = 5'd1;
    wb_valid = 3'b100; wb_addr = {5'd9, 10'd0}; wb_wdata = {32'hDEADBEEF, 64'd0};
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("raw stall", 64'(o_stall[m]), 64'd1);
      chk("xcu grant", 64'(o_ready[m]), 64'b100);
      chk("busy9 set", 64'(o_busy[m][9]), 64'd1);
    end
    tick();
    wb_valid = '0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("wb9 rd_wen", 64'(o_wen[m]), 64'd1);
      chk("wb9 rd_addr", 64'(o_addr[m]), 64'd9);
      chk("wb9 rd_wdata", 64'(o_data[m]), 64'hDEADBEEF);
      chk("bypass stall", 64'(o_stall[m]), 64'd0);
    end
    tick();
    #1 chk("busy9 cleared", 64'(o_busy[0][9]), 64'd0);
    iss_valid = 1'b0;
    tick();

    // Same-cycle set and clear of x9: set wins.
    wb_valid = 3'b001; wb_addr = {10'd0, 5'd9}; wb_wdata = {64'd0, 32'h55};
    #1 chk("alu grant x9", 64'(o_ready[1]), 64'b001);
    tick();
    wb_valid = '0;
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd9; iss_rs1 = '0; iss_rs2 = '0;
    #1 chk("setclr rd_wen", 64'(o_wen[0]), 64'd1);
    chk("setclr stall", 64'(o_stall[0]), 64'd0);
    tick();
    iss_valid = 1'b0;
    #1 chk("set wins rr", 64'(o_busy[0][9]), 64'd1);
    chk("set wins fx", 64'(o_busy[1][9]), 64'd1);
    wb_valid = 3'b100; wb_addr = {5'd9, 10'd0};
    tick();
    wb_valid = '0;
    tick();
    #1 chk("busy9 retired", 64'(o_busy[0][9]), 64'd0);

    // Write to x0 is granted and dropped; pointer still advances.
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    wb_valid = 3'b001; wb_addr = '0; wb_wdata = {64'd0, 32'h1234};
    #1 chk("x0 grant", 64'(o_ready[0]), 64'b001);
    tick();
    wb_valid = 3'b111; wb_addr = {5'd7, 5'd6, 5'd0};
    #1 chk("x0 rd_wen", 64'(o_wen[0]), 64'd0);
    chk("x0 ptr advance", 64'(o_ready[0]), 64'b010);
    tick();
    wb_valid = '0;
    tick();

    // Asynchronous reset with a busy bit and a write in flight.
    iss_valid = 1'b1; iss_long = 1'b1; iss_rd = 5'd3; iss_rs1 = '0; iss_rs2 = '0;
    tick();
    iss_valid = 1'b0;
    wb_valid = 3'b001; wb_addr = {10'd0, 5'd5}; wb_wdata = {64'd0, 32'h77};
    #1 chk("pre-rst busy3", 64'(o_busy[0][3]), 64'd1);
    tick();
    wb_valid = '0;
    #1 chk("pre-rst rd_wen", 64'(o_wen[0]), 64'd1);
    #1 resetn = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async rd_wen", 64'(o_wen[m]), 64'd0);
      chk("async rd_addr", 64'(o_addr[m]), 64'd0);
      chk("async rd_wdata", 64'(o_data[m]), 64'd0);
      chk("async sb_busy", 64'(o_busy[m]), 64'd0);
    end
    tick();
    resetn = 1'b1;
    tick();

    // Randomised traffic; requesters hold until the RR instance grants them.
    rdy = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (!(wb_valid[i] && !rdy[i])) begin
          wb_valid[i]          = 1'($urandom_range(0, 1));
          wb_addr[5*i +: 5]    = 5'($urandom_range(0, 7));
          wb_wdata[32*i +: 32] = $urandom;
        end
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_long  = 1'($urandom_range(0, 1));
      iss_rs1   = 5'($urandom_range(0, 7));
      iss_rs2   = 5'($urandom_range(0, 7));
      iss_rd    = 5'($urandom_range(0, 7));
      #1 rdy = o_ready[0];
      if (c % 700 == 699) begin
        #1 resetn = 1'b0;
        tick();
        resetn = 1'b1;
      end else begin
        tick();
      end
    end
    wb_valid = '0; iss_valid = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xc_rf_wb_sched.md
# xc_rf_wb_sched

Writeback scheduler and scoreboard for the 2-read-1-write forwarding GPR file.
- Shares the single `rd` write port among three writeback requesters (0 = ALU, 1 = LSU, 2 = multi-cycle crypto unit).
- Registers the winning write and drives the file's `rd_wen`/`rd_addr`/`rd_wdata`.
- Tracks destinations of in-flight long-latency ops and stalls issue on RAW/WAW hazards against them.
- Sits between the execute/writeback stages and the register file.

## Interface
Parameters:
- `RR_EN`, 1: 1 = round-robin arbitration; 0 = fixed priority 0 > 1 > 2.

Ports:
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: reset is asynchronous and active-low.
- `wb_valid` in 3: per-requester write request.
- `wb_ready` out 3: per-requester grant; combinational, one-hot or zero.
- `wb_addr` in 15: requester i destination at [5i+4:5i].
- `wb_wdata` in 96: requester i data at [32i+31:32i].
- `iss_valid` in 1: instruction presented at issue.
- `iss_long` in 1: presented instruction writes back through requester 2.
- `iss_rs1` in 5: issue source register 1.
- `iss_rs2` in 5: issue source register 2.
- `iss_rd` in 5: issue destination register.
- `iss_stall` out 1: hazard; issue must hold.
- `rd_wen` out 1: register-file write enable.
- `rd_addr` out 5: register-file write address.
- `rd_wdata` out 32: register-file write data.
- `sb_busy` out 32: scoreboard state; bit 0 is always 0.

## Operation
Arbitration:
- Requester i is granted when `wb_valid[i]` is set and it wins arbitration. Grant means `wb_ready[i]` = 1 in the same cycle.
- At most one grant per cycle.
- Requesters hold `valid`, `addr` and `wdata` stable until ready.
- RR mode:
  - 2-bit pointer `ptr` (0..2) names the highest-priority requester. Search order is ptr, ptr+1, ptr+2 mod 3.
  - On a grant to i, `ptr` becomes (i+1) mod 3.
  - With no grant, `ptr` holds. The value 3 is unreachable.
- Fixed mode: `ptr` is unused.

Write stage:
- On a grant, the output registers capture `addr`/`wdata`.
- `rd_wen` is 1 only if the granted addr != 0.
- A granted write to x0 is accepted and dropped (`rd_wen` = 0).
- With no grant, `rd_wen` = 0; `rd_addr`/`rd_wdata` hold their last values.

Scoreboard:
- `busy[31:1]`:
  - set: `iss_valid & ~iss_stall & iss_long & iss_rd != 0` sets `busy[iss_rd]`.
  - clear: `rd_wen` clears `busy[rd_addr]` at the end of that cycle.
  - Same register set and cleared in one cycle: set wins.
- `iss_stall = iss_valid & (hz(iss_rs1) | hz(iss_rs2) | hz(iss_rd))`.
  - hz(r) = r != 0 & busy[r] & ~(rd_wen & rd_addr == r).
  - The clear bypass is legal because the register file forwards `rd_wdata` in that cycle.
- Only requester-2 writes are expected to clear busy bits; any requester's write to a busy register clears it.

## Timing
- Reset values: `rd_wen` 0, `rd_addr` 0, `rd_wdata` 0, `ptr` 0, `busy` all 0. `wb_ready` and `iss_stall` are combinational and evaluate to 0 while no request or issue is presented.
- Request accepted in cycle N → `rd_wen`/`rd_addr`/`rd_wdata` valid in cycle N+1, for exactly one cycle.
- Throughput: one write per cycle. Three continuous RR requesters are each granted once every 3 cycles.
- `iss_stall` depends combinationally on `iss_*`, `busy` and the output registers. It has no path from `wb_*`.
- Reset mid-operation: every register clears immediately.
  - Pending requests see `wb_ready` re-evaluated from `ptr` = 0.
  - In-flight long ops lose their busy bits. The pipeline flushes on reset.

## Structure
- Shared package `xc_rf_pkg`: `XC_RF_NREQ` = 3, `XC_RF_AW` = 5, `XC_RF_DW` = 32, and requester index constants `XC_WB_ALU` = 0, `XC_WB_LSU` = 1, `XC_WB_XCU` = 2.
- One sub-module, `xc_rf_scoreboard`: busy vector, set/clear logic and hazard compare.
- The arbiter and output registers stay in the top module.

## Test plan
- RR mode, reset then all three valid continuously, addrs 5/6/7, data A/B/C: grants 0,1,2,0,… and `rd_addr` 5,6,7,5 starting one cycle after the first grant.
- Fixed mode, `wb_valid` = 3'b110 for 2 cycles: requester 1 granted twice; requester 2 never granted while 1 is valid.
- Long issue with `iss_rd` = 9:
  - Next-cycle issue with `iss_rs1` = 9: `iss_stall` = 1.
  - Requester 2 writes x9 = 0xDEADBEEF: in the `rd_wen` cycle, `iss_stall` = 0 and `busy[9]` = 0 next cycle.
- Long issue to x9 while `rd_wen` writes x9 in the same cycle: `busy[9]` remains 1 afterwards.
- Requester 0 granted with addr 0, data 0x1234: `wb_ready[0]` = 1, next cycle `rd_wen` = 0, `ptr` advances to 1.
- `resetn` asserted while `busy[3]` = 1 and `rd_wen` = 1: all outputs 0 and `sb_busy` = 0 without waiting for a clock edge.
